seven_seg_decimal_display: RTL and testbench

- Parametrised decimal driver for a multiplexed 7-segment display. It is the successor to the ad-hoc BCD/scan logic in the lab top levels.
- Converts an unsigned binary value to BCD using a sequential double-dabble engine, one bit per cycle, with no combinational divide/modulo.
- Scans n_digits digits round-robin at a fixed per-digit rate.
- Sits between game/lab logic, which supplies a count, and the board's abcdefgh/digit pins.

---
 rtl/seven_seg_pkg.sv | 48 ++++
 rtl/bin_to_bcd_seq.sv | 69 ++++++
 rtl/seven_seg_decimal_display.sv | 107 ++++++++++
 tb/tb_seven_seg_decimal_display.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: segment patterns, converter state and BCD nibble types shared by the display driver
package seven_seg_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [1:0] conv_state_t;

    localparam conv_state_t IDLE  = 2'd0;
    localparam conv_state_t SHIFT = 2'd1;
    localparam conv_state_t DONE  = 2'd2;

    // active-high patterns, bit7 = a ... bit1 = g, bit0 = h (dot)
    localparam logic [7:0] SEG_0    = 8'hFC;
    localparam logic [7:0] SEG_1    = 8'h60;
    localparam logic [7:0] SEG_2    = 8'hDA;
    localparam logic [7:0] SEG_3    = 8'hF2;
    localparam logic [7:0] SEG_4    = 8'h66;
    localparam logic [7:0] SEG_5    = 8'hB6;
    localparam logic [7:0] SEG_6    = 8'hBE;
    localparam logic [7:0] SEG_7    = 8'hE0;
    localparam logic [7:0] SEG_8    = 8'hFE;
    localparam logic [7:0] SEG_9    = 8'hF6;
    localparam logic [7:0] SEG_DASH = 8'h02;
    localparam logic [7:0] SEG_OFF  = 8'h00;

    function automatic logic [7:0] seg_decode(input bcd_t d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_OFF;
        endcase
    endfunction

    // accumulator must hold every decimal digit of the widest input plus one overflow nibble
    function automatic int conv_nibbles(input int w_value, input int n_digits);
        int a;
        a = (w_value + 2) / 3 + 1;
        return a > n_digits + 1 ? a : n_digits + 1;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble converter, one input bit per cycle, with a one-deep pending load
module bin_to_bcd_seq
    import seven_seg_pkg::*;
#(
    parameter int w_value = 16,
    parameter int n_nib   = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [w_value-1:0]   value,
    input  logic                 load,
    output logic                 busy,
    output logic                 done,
    output logic [4*n_nib-1:0]   bcd
);

    localparam int w_cnt = w_value > 1 ? $clog2(w_value) : 1;

    conv_state_t        state;
    logic [w_value-1:0] sr;
    logic [w_value-1:0] pend;
    logic               pend_full;
    logic [w_cnt-1:0]   cnt;
    logic [4*n_nib-1:0] adj;
    logic               start;
    logic [w_value-1:0] start_val;

    assign busy      = state != IDLE;
    assign done      = state == DONE;
    assign start     = (state == IDLE && load) || (done && (load || pend_full));
    assign start_val = load ? value : pend;

    // add 3 to every nibble of 5 or more so the following shift carries correctly into the next digit
    always_comb begin
        adj = bcd;
        for (int i = 0; i < n_nib; i++)
            adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end

    // state sequencing, pending slot and the shift datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sr        <= '0;
            bcd       <= '0;
            cnt       <= '0;
            pend      <= '0;
            pend_full <= 1'b0;
        end else if (start) begin
            state     <= SHIFT;
            sr        <= start_val;
            bcd       <= '0;
            cnt       <= '0;
            pend_full <= 1'b0;
        end else if (state == SHIFT) begin
            {bcd, sr} <= {adj, sr} << 1;
            cnt       <= cnt + 1'b1;
            if (cnt == w_cnt'(w_value - 1))
                state <= DONE;
            if (load) begin
                pend      <= value;
                pend_full <= 1'b1;
            end
        end else if (done) begin
            state <= IDLE;
        end
    end

endmodule

// File: rtl/seven_seg_decimal_display.sv
// seven_seg_decimal_display: binary-to-decimal multiplexed 7-segment driver; SEVEN_SEG_LZ_BLANK_EN enables leading-zero blanking
module seven_seg_decimal_display
    import seven_seg_pkg::*;
#(
    parameter int clk_mhz          = 50,
    parameter int digit_hz         = 1000,
    parameter int w_value          = 16,
    parameter int n_digits         = 4,
    parameter int w_digit          = 8,
    parameter bit seg_active_low   = 1'b1,
    parameter bit digit_active_low = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [w_value-1:0]  value,
    input  logic                value_load,
    input  logic [n_digits-1:0] dots,
    output logic                busy,
    output logic                overflow,
    output logic [7:0]          abcdefgh,
    output logic [w_digit-1:0]  digit
);

    localparam int dwell_raw = clk_mhz * 1000000 / digit_hz;
    localparam int dwell     = dwell_raw < 1 ? 1 : dwell_raw;
    localparam int w_pre     = dwell > 1 ? $clog2(dwell) : 1;
    localparam int w_sel     = n_digits > 1 ? $clog2(n_digits) : 1;
    localparam int n_nib     = conv_nibbles(w_value, n_digits);

    logic                  conv_done;
    logic [4*n_nib-1:0]    acc;
    logic [4*n_digits-1:0] disp;
    logic [w_pre-1:0]      pre;
    logic [w_sel-1:0]      sel;
    logic [n_digits-1:0]   shown;
    bcd_t                  cur;
    logic [7:0]            seg_nxt;

    bin_to_bcd_seq #(
        .w_value (w_value),
        .n_nib   (n_nib)
    ) u_conv (
        .clk   (clk),
        .rst   (rst),
        .value (value),
        .load  (value_load),
        .busy  (busy),
        .done  (conv_done),
        .bcd   (acc)
    );

    // commit a finished conversion in one edge so the display never shows a partial result
    always_ff @(posedge clk) begin
        if (rst) begin
            disp     <= '0;
            overflow <= 1'b0;
        end else if (conv_done) begin
            disp     <= acc[4*n_digits-1:0];
            overflow <= |acc[4*n_nib-1:4*n_digits];
        end
    end

    // dwell prescaler and round-robin digit select
    always_ff @(posedge clk) begin
        if (rst) begin
            pre <= '0;
            sel <= '0;
        end else if (pre == w_pre'(dwell - 1)) begin
            pre <= '0;
            sel <= sel == w_sel'(n_digits - 1) ? '0 : sel + 1'b1;
        end else begin
            pre <= pre + 1'b1;
        end
    end

`ifdef SEVEN_SEG_LZ_BLANK_EN
    // a digit stays lit if it or any higher digit is nonzero; digit 0 always stays lit
    always_comb begin
        logic nz;
        nz    = 1'b0;
        shown = '0;
        shown[0] = 1'b1;
        for (int k = n_digits - 1; k > 0; k--) begin
            nz       = nz | (disp[4*k +: 4] != 4'd0);
            shown[k] = nz;
        end
    end
`else
    assign shown = '1;
`endif

    assign cur     = disp[4*sel +: 4];
    assign seg_nxt = overflow ? SEG_DASH | {7'b0, dots[sel]} :
                     shown[sel] ? seg_decode(cur) | {7'b0, dots[sel]} : SEG_OFF;

    // register segments and enable together, applying board polarity
    always_ff @(posedge clk) begin
        if (rst) begin
            abcdefgh <= SEG_OFF ^ {8{seg_active_low}};
            digit    <= {w_digit{digit_active_low}};
        end else begin
            abcdefgh <= seg_nxt ^ {8{seg_active_low}};
            digit    <= (w_digit'(1) << sel) ^ {w_digit{digit_active_low}};
        end
    end

endmodule

// File: tb/tb_seven_seg_decimal_display.sv
// tb_seven_seg_decimal_display: scoreboard bench with random loads against a decimal reference model
module tb_seven_seg_decimal_display;

    localparam int dwell = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic        value_load = 1'b0;
    logic [3:0]  dots = '0;
    logic        busy, overflow;
    logic [7:0]  abcdefgh, digit;
    logic        busy3, ovf3;
    logic [7:0]  seg3, digit3;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int busy_q[$];
    int disp_m  = 0;
    int shown_v = 0;
    logic [3:0] shown_d = '0;
    bit  was_rst = 1'b1;
    int  k = 0;
    int  brun = 0;
    int  a, b, kk;

    int         p10[6] = '{1, 10, 100, 1000, 10000, 100000};
    logic [7:0] tbl[10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

    always #5 clk = ~clk;

    seven_seg_decimal_display #(
        .clk_mhz  (4),
        .digit_hz (1000000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .value_load (value_load),
        .dots       (dots),
        .busy       (busy),
        .overflow   (overflow),
        .abcdefgh   (abcdefgh),
        .digit      (digit)
    );

    seven_seg_decimal_display #(
        .clk_mhz          (4),
        .digit_hz         (1000000),
        .w_value          (10),
        .n_digits         (3),
        .seg_active_low   (1'b0),
        .digit_active_low (1'b1)
    ) dut3 (
        .clk        (clk),
        .rst        (rst),
        .value      (10'd0),
        .value_load (1'b0),
        .dots       (3'b000),
        .busy       (busy3),
        .overflow   (ovf3),
        .abcdefgh   (seg3),
        .digit      (digit3)
    );

    function automatic void chk(input bit ok, input string nm, input longint act, input longint exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endfunction

    // expected segment byte (common anode) for decimal value v on digit j with dot bits d
    function automatic logic [7:0] exp_seg(input int v, input int j, input logic [3:0] d);
        logic [7:0] p;
        if (v >= 10000) begin
            p = 8'h02 | {7'b0, d[j]};
        end else begin
            p = tbl[(v / p10[j]) % 10] | {7'b0, d[j]};
`ifdef SEVEN_SEG_LZ_BLANK_EN
            if (j > 0 && v < p10[j]) p = 8'h00;
`endif
        end
        return ~p;
    endfunction

    // monitor: scan order, segments, overflow, busy runs and commit scoreboard
    always @(negedge clk) begin
        int j, j3;
        logic [7:0] es;
        if (was_rst) begin
            chk(abcdefgh == 8'hFF, "reset_seg", abcdefgh, 8'hFF);
            chk(digit == 8'h00, "reset_digit", digit, 8'h00);
            chk(busy == 1'b0, "reset_busy", busy, 0);
            chk(overflow == 1'b0, "reset_overflow", overflow, 0);
            chk(digit3 == 8'hFF, "reset_digit3", digit3, 8'hFF);
            chk(seg3 == 8'h00, "reset_seg3", seg3, 8'h00);
            k = 0;
        end else begin
            j  = (k / dwell) % 4;
            j3 = (k / dwell) % 3;
            es = exp_seg(shown_v, j, shown_d);
            chk(digit == 8'(1 << j), "scan_digit", digit, 1 << j);
            chk(abcdefgh == es, "segments", abcdefgh, es);
            chk(overflow == (disp_m >= 10000), "overflow", overflow, disp_m >= 10000);
            chk(digit3 == ~8'(1 << j3), "scan_digit3", digit3, ~8'(1 << j3));
            k++;
        end
        if (busy) begin
            brun++;
        end else if (brun > 0) begin
            chk(busy_q.size() > 0, "unexpected_busy", brun, 0);
            if (busy_q.size() > 0) chk(brun == busy_q[0], "busy_cycles", brun, busy_q[0]);
            if (busy_q.size() > 0) void'(busy_q.pop_front());
            brun = 0;
        end
        shown_v = disp_m;
        shown_d = dots;
        if (rst) begin
            exp_q.delete();
            disp_m  = 0;
            shown_v = 0;
        end else if (dut.conv_done) begin
            chk(exp_q.size() > 0, "unexpected_commit", 1, 0);
            if (exp_q.size() > 0) disp_m = exp_q.pop_front();
        end
        was_rst = rst;
    end

    task automatic pulse(input int v);
        value      = 16'(v);
        value_load = 1'b1;
        @(posedge clk);
        #1 value_load = 1'b0;
    endtask

    task automatic settle();
        int n;
        n = 0;
        while ((busy || busy_q.size() > 0 || exp_q.size() > 0) && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        chk(n < 200, "idle_timeout", n, 200);
        repeat (4 * dwell + 2) @(posedge clk);
        #1;
    endtask

    task automatic one(input int v);
        exp_q.push_back(v);
        busy_q.push_back(17);
        pulse(v);
        settle();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2 * dwell) @(posedge clk);
        #1;
        one(1234);
        one(9999);
        one(10000);
        one(5);
        exp_q.push_back(100);
        exp_q.push_back(7);
        busy_q.push_back(34);
        pulse(100);
        @(posedge clk);
        #1 pulse(42);
        pulse(7);
        settle();
        dots = 4'b0100;
        one(0);
        one(40);
        one(400);
        dots = 4'b0000;
        exp_q.push_back(65535);
        busy_q.push_back(5);
        pulse(65535);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        settle();
        for (int it = 0; it < 40; it++) begin
            a = $urandom_range(0, 65535);
            if ($urandom_range(0, 1) == 1) a = a % p10[$urandom_range(1, 5)];
            dots = 4'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                b  = $urandom_range(0, 65535);
                kk = $urandom_range(1, 17);
                exp_q.push_back(a);
                exp_q.push_back(b);
                busy_q.push_back(34);
                pulse(a);
                repeat (kk - 1) begin
                    @(posedge clk);
                    #1;
                end
                pulse(b);
                settle();
            end else begin
                one(a);
            end
        end
        chk(exp_q.size() == 0, "commits_left", exp_q.size(), 0);
        chk(busy_q.size() == 0, "busy_runs_left", busy_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 want 0");
        $fatal(1);
    end

endmodule
